// File: rtl/uart_tx_sched_if.sv
// Requester handshake and uart_tx drive signals for uart_tx_sched, bundled with
// master (requesters/transmitter side) and slave (scheduler) views.
interface uart_tx_sched_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_parity;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx_write;
    logic [7:0]        tx_data;
    logic              tx_paritymode;
    logic              tx_txrdy;
    logic              busy;
    logic              ack_err;

    modport master (
        output req_valid, req_data, req_parity, req_last, tx_txrdy,
        input  req_ready, grant, tx_write, tx_data, tx_paritymode, busy, ack_err
    );

    modport slave (
        input  req_valid, req_data, req_parity, req_last, tx_txrdy,
        output req_ready, grant, tx_write, tx_data, tx_paritymode, busy, ack_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte requesters, with
// burst lock per grant, MAXBURST forced rotation and a txrdy acknowledge timeout.
module uart_tx_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MAXBURST    = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic           mclkx16,
    input  logic           reset,
    uart_tx_sched_if.slave bus
);
    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, WRITE, ACK, DRAIN} state_t;

    state_t          state, state_nx;
    logic            rdy_m, rdy_s;
    logic [PW-1:0]   ptr, owner, win, cap_idx;
    logic            win_ok;
    int unsigned     idx;
    logic [7:0]      bcnt, tcnt;
    logic            wphase, last_q, ack_err_q, par_q;
    logic [7:0]      data_q;
    logic            capture, release_g, timeout;
    logic [NREQ-1:0] ready;

    // txrdy comes from the txclk divider; both flops reset high so a fresh
    // block sees the transmitter as ready.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            rdy_m <= 1'b1;
            rdy_s <= 1'b1;
        end else begin
            rdy_m <= bus.tx_txrdy;
            rdy_s <= rdy_m;
        end
    end

    always_comb begin : arbitrate
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (k + 32'(ptr)) % NREQ;
            if (!win_ok && bus.req_valid[idx]) begin
                win    = PW'(idx);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin : fsm_next
        state_nx  = state;
        capture   = 1'b0;
        release_g = 1'b0;
        timeout   = 1'b0;
        ready     = '0;
        cap_idx   = owner;
        unique case (state)
            IDLE: begin
                if (rdy_s && win_ok) begin
                    ready[win] = 1'b1;
                    capture    = 1'b1;
                    cap_idx    = win;
                    state_nx   = WRITE;
                end
            end
            WRITE: begin
                if (wphase) state_nx = ACK;
            end
            ACK: begin
                if (!rdy_s) begin
                    state_nx = DRAIN;
                end else if (tcnt == 8'(ACK_TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (rdy_s) begin
                    if (!last_q && (bcnt < 8'(MAXBURST)) && bus.req_valid[owner]) begin
                        ready[owner] = 1'b1;
                        capture      = 1'b1;
                        state_nx     = WRITE;
                    end else begin
                        release_g = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Requesters must not see a handshake while reset is held.
        if (reset) ready = '0;
    end

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            wphase    <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state  <= state_nx;
            wphase <= (state == WRITE) && !wphase;
            tcnt   <= (state == ACK) ? tcnt + 8'd1 : '0;
            if (capture) begin
                owner  <= cap_idx;
                data_q <= bus.req_data[8*cap_idx +: 8];
                par_q  <= bus.req_parity[cap_idx];
                last_q <= bus.req_last[cap_idx];
                bcnt   <= (state == IDLE) ? 8'd1 : bcnt + 8'd1;
            end
            if (release_g) ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            if (timeout) ack_err_q <= 1'b1;
        end
    end

    assign bus.req_ready     = ready;
    assign bus.grant         = (state == IDLE) ? '0 : ({{(NREQ-1){1'b0}}, 1'b1} << owner);
    assign bus.tx_write      = (state == WRITE);
    assign bus.tx_data       = data_q;
    assign bus.tx_paritymode = par_q;
    assign bus.busy          = (state != IDLE);
    assign bus.ack_err       = ack_err_q;
endmodule
